// File: rtl/clk_div_pow2_gen_if.sv
// Control and status bundle for the power-of-two clock-enable generator.
// The master drives run/restart/select; the slave returns tick, square and period status.
interface clk_div_pow2_gen_if #(
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned BASE_EXP = 17
);
  localparam int unsigned CNT_W = BASE_EXP + 2**SEL_W;

  logic             EN;
  logic             APPLY_NOW;
  logic [SEL_W-1:0] SW_IN;
  logic             TICK;
  logic             SQ_OUT;
  logic [SEL_W-1:0] SEL_ACT;
  logic [CNT_W-1:0] PERIOD_OUT;

  modport master (
    output EN, APPLY_NOW, SW_IN,
    input  TICK, SQ_OUT, SEL_ACT, PERIOD_OUT
  );

  modport slave (
    input  EN, APPLY_NOW, SW_IN,
    output TICK, SQ_OUT, SEL_ACT, PERIOD_OUT
  );
endinterface

// File: rtl/clk_div_pow2_gen.sv
// Switch-selected power-of-two clock-enable generator.
// Period N = 2**(BASE_EXP + SEL_ACT) clocks. A new select is picked up only at the
// period boundary or on APPLY_NOW, so a period is never truncated or stretched.
module clk_div_pow2_gen #(
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned BASE_EXP = 17
) (
  input  logic               CLK,
  input  logic               RST_N,
  clk_div_pow2_gen_if.slave  bus
);
  localparam int unsigned CNT_W = BASE_EXP + 2**SEL_W;

  logic [SEL_W-1:0] sw_meta_q, sw_s_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_inc;

  // Period derived from the select in force; largest exponent still fits CNT_W bits.
  always_comb begin
    period   = CNT_W'(1) << (BASE_EXP + 32'(sel_q));
    last_cnt = period - CNT_W'(1);
    half     = period >> 1;
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  // Next-state: restart beats wrap beats count; EN=0 holds everything but TICK.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (bus.APPLY_NOW) begin
      cnt_d = '0;
      sel_d = sw_s_q;
      sq_d  = 1'b1;
    end else if (bus.EN) begin
      if (cnt_q == last_cnt) begin
        cnt_d  = '0;
        sel_d  = sw_s_q;
        tick_d = 1'b1;
        sq_d   = 1'b1;
      end else begin
        cnt_d = cnt_inc;
        sq_d  = (cnt_inc < half);
      end
    end
  end

  // State registers with synchronous active-low reset; synchroniser loads every cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      sw_meta_q <= bus.SW_IN;
      sw_s_q    <= sw_meta_q;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign bus.TICK       = tick_q;
  assign bus.SQ_OUT     = sq_q;
  assign bus.SEL_ACT    = sel_q;
  assign bus.PERIOD_OUT = period;
endmodule

// File: tb/tb_clk_div_pow2_gen.sv
// Bench for clk_div_pow2_gen: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the counter/select rules.
module tb_clk_div_pow2_gen;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned BASE_EXP = 2;

  logic clk;
  logic rst_n;

  clk_div_pow2_gen_if #(.SEL_W(SEL_W), .BASE_EXP(BASE_EXP)) bus ();

  clk_div_pow2_gen #(.SEL_W(SEL_W), .BASE_EXP(BASE_EXP)) u_dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_cnt;
  int m_sel;
  int m_sync[2];
  bit m_tick;
  bit m_sq;

  function automatic int n_of(input int s);
    return 1 << (BASE_EXP + s);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int sw_s_old;
    sw_s_old = m_sync[1];
    if (!rst_n) begin
      m_sync[0] = 0;
      m_sync[1] = 0;
      m_cnt     = 0;
      m_sel     = 0;
      m_tick    = 0;
      m_sq      = 0;
    end else begin
      m_sync[1] = m_sync[0];
      m_sync[0] = int'(bus.SW_IN);
      if (bus.APPLY_NOW) begin
        m_cnt  = 0;
        m_sel  = sw_s_old;
        m_tick = 0;
        m_sq   = 1;
      end else if (bus.EN) begin
        if (m_cnt == n_of(m_sel) - 1) begin
          m_cnt  = 0;
          m_sel  = sw_s_old;
          m_tick = 1;
          m_sq   = 1;
        end else begin
          m_cnt  = m_cnt + 1;
          m_tick = 0;
          m_sq   = (m_cnt < n_of(m_sel) / 2);
        end
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("tick", 32'(bus.TICK), 32'(m_tick));
    check_val("sq_out", 32'(bus.SQ_OUT), 32'(m_sq));
    check_val("sel_act", 32'(bus.SEL_ACT), 32'(m_sel));
    check_val("period_out", 32'(bus.PERIOD_OUT), 32'(n_of(m_sel)));
  endtask

  // Step until TICK is seen; edges = -1 if the bound expires.
  task automatic wait_tick(input int bound, output int edges);
    edges = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (bus.TICK === 1'b1) begin
        edges = i;
        return;
      end
    end
  endtask

  int tick_edges[$];
  int edges;
  bit pat[4];

  initial begin
    pat = '{1'b1, 1'b1, 1'b0, 1'b0};
    rst_n         = 1'b0;
    bus.EN        = 1'b1;
    bus.APPLY_NOW = 1'b0;
    bus.SW_IN     = 2'd3;

    // Reset values
    repeat (3) step();
    check_val("rst_tick", 32'(bus.TICK), 32'd0);
    check_val("rst_sq", 32'(bus.SQ_OUT), 32'd0);
    check_val("rst_sel", 32'(bus.SEL_ACT), 32'd0);
    check_val("rst_period", 32'(bus.PERIOD_OUT), 32'd4);

    // Free run at N=4
    rst_n     = 1'b1;
    bus.SW_IN = 2'd0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (bus.TICK === 1'b1) tick_edges.push_back(e);
      if (e >= 4 && e <= 7) check_val("sq_pattern", 32'(bus.SQ_OUT), 32'(pat[e-4]));
    end
    check_val("tick_count_n4", 32'(tick_edges.size()), 32'd5);
    foreach (tick_edges[i]) check_val("tick_edge_n4", 32'(tick_edges[i]), 32'(4 * (i + 1)));

    // Select change mid-period lands at the next wrap only
    step();
    bus.SW_IN = 2'd1;
    step();
    step();
    check_val("sel_held_mid", 32'(bus.SEL_ACT), 32'd0);
    step();
    check_val("wrap_tick", 32'(bus.TICK), 32'd1);
    check_val("wrap_sel", 32'(bus.SEL_ACT), 32'd1);
    wait_tick(100, edges);
    check_val("period_n8", 32'(edges), 32'd8);

    // APPLY_NOW mid-period: no tick, immediate N=32
    bus.SW_IN = 2'd3;
    step();
    step();
    bus.APPLY_NOW = 1'b1;
    step();
    bus.APPLY_NOW = 1'b0;
    check_val("apply_tick", 32'(bus.TICK), 32'd0);
    check_val("apply_sel", 32'(bus.SEL_ACT), 32'd3);
    check_val("apply_period", 32'(bus.PERIOD_OUT), 32'd32);
    wait_tick(100, edges);
    check_val("period_n32", 32'(edges), 32'd32);

    // Hold with EN=0 at cnt=5 of N=8
    bus.SW_IN = 2'd1;
    repeat (2) step();
    bus.APPLY_NOW = 1'b1;
    step();
    bus.APPLY_NOW = 1'b0;
    repeat (5) step();
    bus.EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("hold_tick", 32'(bus.TICK), 32'd0);
      check_val("hold_sq", 32'(bus.SQ_OUT), 32'd0);
    end
    bus.EN = 1'b1;
    wait_tick(100, edges);
    check_val("resume_edges", 32'(edges), 32'd3);

    // Reset mid-period at cnt=6 of N=16
    bus.SW_IN = 2'd2;
    repeat (2) step();
    bus.APPLY_NOW = 1'b1;
    step();
    bus.APPLY_NOW = 1'b0;
    bus.SW_IN     = 2'd0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    check_val("rst2_tick", 32'(bus.TICK), 32'd0);
    check_val("rst2_sq", 32'(bus.SQ_OUT), 32'd0);
    check_val("rst2_sel", 32'(bus.SEL_ACT), 32'd0);
    check_val("rst2_period", 32'(bus.PERIOD_OUT), 32'd4);
    rst_n = 1'b1;
    wait_tick(100, edges);
    check_val("post_rst_edges", 32'(edges), 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.EN        = ($urandom_range(0, 9) != 0);
      bus.APPLY_NOW = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) bus.SW_IN = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
